// File: rtl/vga_line_prefetch_if.sv
// rtl/vga_line_prefetch_if.sv - memory-controller read/command port between prefetcher and memory
interface vga_line_prefetch_if;
  logic        mem_cmd_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_cmd_full;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_rd_empty;
  logic        mem_rd_overflow;
  logic        mem_rd_error;

  // prefetcher side: issues commands and pops read words
  modport master (
    output mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr, mem_rd_en,
    input  mem_cmd_full, mem_rd_data, mem_rd_empty, mem_rd_overflow, mem_rd_error
  );

  // memory-controller side
  modport slave (
    input  mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr, mem_rd_en,
    output mem_cmd_full, mem_rd_data, mem_rd_empty, mem_rd_overflow, mem_rd_error
  );
endinterface

// File: rtl/vga_line_prefetch.sv
// rtl/vga_line_prefetch.sv - circular burst prefetch ring feeding VGA scan-out one pixel per cycle
module vga_line_prefetch #(
  parameter int          SCREEN_W    = 256,
  parameter int          SCREEN_H    = 192,
  parameter int          BUF_DEPTH   = 256,
  parameter int          BURST_WORDS = 32,
  parameter logic [13:0] ADDR_PREFIX = 14'h0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        calib_done,
  input  logic [7:0]                  x_coord,
  input  logic                        invalidate,
  input  logic                        resync,
  input  logic                        err_clear,
  output logic [7:0]                  rgb,
  output logic                        empty,
  output logic [$clog2(BUF_DEPTH):0]  level,
  output logic                        underrun,
  output logic                        mem_err,
  vga_line_prefetch_if.master         mem
);

  localparam int FRAME       = SCREEN_W * SCREEN_H;
  localparam int BURST_BYTES = 4 * BURST_WORDS;
  localparam int IDXW        = $clog2(BUF_DEPTH);
  localparam int LW          = IDXW + 1;
  localparam int WORDS       = BUF_DEPTH / 4;

  typedef enum logic [1:0] {IDLE, CMD, READ, DRAIN} state_t;

  state_t            state;
  logic [15:0]       head;
  logic [15:0]       fetch_ptr;
  logic [LW-1:0]     valid_len;
  logic [IDXW-1:0]   wr_idx;
  logic [6:0]        words_left;

  // Ring stored as 32-bit words: every write is a whole word-aligned popped word.
  logic [31:0]       ram [WORDS];

  logic              pop;
  logic              write_word;
  logic              inv_ok;
  logic              inv_empty;
  logic              err_seen;
  logic              room;
  logic              cmd_go;
  logic [IDXW-1:0]   rd_idx;
  logic [15:0]       head_next;
  logic [15:0]       fetch_next;

  assign rd_idx     = IDXW'(x_coord);
  assign empty      = (valid_len == '0);
  assign level      = valid_len;

  assign mem.mem_cmd_instr = 3'b001;
  assign mem.mem_cmd_bl    = 6'(BURST_WORDS - 1);
  // Pop straight off the FIFO flag so a full burst streams at one word per cycle.
  assign mem.mem_rd_en     = calib_done && (state == READ || state == DRAIN) && !mem.mem_rd_empty;

  assign pop        = mem.mem_rd_en;
  // A word popped in the resync cycle belongs to the abandoned stream and is dropped.
  assign write_word = pop && (state == READ) && !resync;
  assign inv_ok     = invalidate && !empty && !resync;
  assign inv_empty  = invalidate && empty && !resync;
  assign err_seen   = mem.mem_rd_error || mem.mem_rd_overflow;
  assign room       = (valid_len <= LW'(BUF_DEPTH - BURST_BYTES));
  assign cmd_go     = (state == CMD) && !mem.mem_cmd_full && !resync;
  assign head_next  = (head == 16'(FRAME - 1)) ? 16'd0 : head + 16'd1;
  assign fetch_next = (fetch_ptr == 16'(FRAME - BURST_BYTES)) ? 16'd0 : fetch_ptr + 16'(BURST_BYTES);

  // Ring write port: popped word lands at the current write index.
  always_ff @(posedge clk) begin
    if (write_word) ram[wr_idx[IDXW-1:2]] <= mem.mem_rd_data;
  end

  // Pixel read: registered byte select, keeps running while memory is uncalibrated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb <= 8'd0;
    else        rgb <= ram[rd_idx[IDXW-1:2]][{rd_idx[1:0], 3'b000} +: 8];
  end

  // Fetch FSM with ring bookkeeping, sticky flags and registered command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      head                  <= '0;
      fetch_ptr             <= '0;
      valid_len             <= '0;
      wr_idx                <= '0;
      words_left            <= '0;
      underrun              <= 1'b0;
      mem_err               <= 1'b0;
      mem.mem_cmd_en        <= 1'b0;
      mem.mem_cmd_byte_addr <= '0;
    end else begin
      mem.mem_cmd_en <= 1'b0;
      if (calib_done) begin
        if (resync)                    valid_len <= '0;
        else if (write_word && inv_ok) valid_len <= valid_len + LW'(3);
        else if (write_word)           valid_len <= valid_len + LW'(4);
        else if (inv_ok)               valid_len <= valid_len - LW'(1);

        if (resync)      head <= '0;
        else if (inv_ok) head <= head_next;

        if (resync)          wr_idx <= '0;
        else if (write_word) wr_idx <= wr_idx + IDXW'(4);

        if (resync)      fetch_ptr <= '0;
        else if (cmd_go) fetch_ptr <= fetch_next;

        if (inv_empty)      underrun <= 1'b1;
        else if (err_clear) underrun <= 1'b0;

        if (err_seen)       mem_err <= 1'b1;
        else if (err_clear) mem_err <= 1'b0;

        case (state)
          IDLE: begin
            if (room) state <= CMD;
          end
          CMD: begin
            if (resync) begin
              state <= IDLE;
            end else if (cmd_go) begin
              mem.mem_cmd_en        <= 1'b1;
              mem.mem_cmd_byte_addr <= {ADDR_PREFIX, fetch_ptr};
              words_left            <= 7'(BURST_WORDS);
              state                 <= READ;
            end
          end
          READ, DRAIN: begin
            if (pop) words_left <= words_left - 7'd1;
            if (pop && words_left == 7'd1) state <= IDLE;
            else if (resync)               state <= DRAIN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_line_prefetch.sv
// tb/tb_vga_line_prefetch.sv - randomized self-checking bench for vga_line_prefetch
module tb_vga_line_prefetch;
  localparam int BURST = 32;
  localparam int FRAME = 49152;

  logic       clk = 1'b0;
  logic       rst_n, calib_done, invalidate, resync, err_clear;
  logic [7:0] x_coord, rgb;
  logic       empty, underrun, mem_err;
  logic [8:0] level;

  vga_line_prefetch_if bus();

  vga_line_prefetch dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .x_coord(x_coord),
    .invalidate(invalidate), .resync(resync), .err_clear(err_clear),
    .rgb(rgb), .empty(empty), .level(level), .underrun(underrun),
    .mem_err(mem_err), .mem(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] memq[$];
  logic [7:0]  ring[256];
  bit          known[256];
  int          m_level, m_head, m_wr, outstanding, exp_addr, ncmd, npop, last_addr;
  bit          discard, m_under, m_err, saw_addr_wrap, saw_head_wrap, fifo_off;
  int          stall_pct, full_pct, force_x;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // frame content: byte at frame address a
  function automatic logic [7:0] pix(input int a);
    logic [15:0] v;
    v = a[15:0];
    return v[7:0] ^ v[15:8] ^ 8'h3c;
  endfunction

  task automatic step(input bit inv, input bit rs, input bit ec, input bit ovf, input bit er);
    bit          pop, cmd, chk_rgb, exp_rd_en, set_u, set_e;
    logic [29:0] caddr;
    logic [5:0]  cbl;
    logic [2:0]  cinstr;
    logic [7:0]  exp_rgb;
    logic [31:0] w;
    int          lvl0, a;
    @(negedge clk);
    invalidate = inv; resync = rs; err_clear = ec;
    bus.mem_rd_overflow = ovf; bus.mem_rd_error = er;
    x_coord = (force_x >= 0) ? 8'(force_x) : 8'($urandom);
    bus.mem_cmd_full = ($urandom_range(0, 99) < full_pct);
    bus.mem_rd_empty = (memq.size() == 0) || fifo_off || ($urandom_range(0, 99) < stall_pct);
    bus.mem_rd_data  = (memq.size() != 0) ? memq[0] : 32'h0;
    #1;
    exp_rd_en = calib_done && (outstanding > 0) && !bus.mem_rd_empty;
    check("rd_en", 32'(bus.mem_rd_en), 32'(exp_rd_en));
    pop     = bus.mem_rd_en && !bus.mem_rd_empty && (memq.size() != 0);
    cmd     = bus.mem_cmd_en;
    caddr   = bus.mem_cmd_byte_addr;
    cbl     = bus.mem_cmd_bl;
    cinstr  = bus.mem_cmd_instr;
    chk_rgb = known[x_coord];
    exp_rgb = ring[x_coord];
    @(posedge clk);
    #1;
    if (cmd) begin
      check("one_outstanding", 32'(outstanding), 32'd0);
      check("cmd_addr", 32'(caddr), 32'(exp_addr));
      check("cmd_bl", 32'(cbl), 32'd31);
      check("cmd_instr", 32'(cinstr), 32'd1);
      if (caddr[15:0] == 16'h0000 && last_addr == 16'hBF80) saw_addr_wrap = 1;
      last_addr = int'(caddr[15:0]);
      for (int i = 0; i < BURST; i++) begin
        a = int'(caddr[15:0]) + 4 * i;
        memq.push_back({pix(a + 3), pix(a + 2), pix(a + 1), pix(a)});
      end
      outstanding = BURST;
      discard = 0;
      exp_addr = (exp_addr + 4 * BURST) % FRAME;
      ncmd++;
    end
    if (calib_done) begin
      lvl0 = m_level;
      if (pop) begin
        w = memq.pop_front();
        outstanding--;
        npop++;
        if (!discard && !rs) begin
          for (int k = 0; k < 4; k++) begin
            ring[(m_wr + k) & 255]  = w[8*k +: 8];
            known[(m_wr + k) & 255] = 1;
          end
          m_wr = (m_wr + 4) & 255;
          m_level += 4;
        end
      end
      set_u = inv && !rs && lvl0 == 0;
      set_e = ovf || er;
      if (rs) begin
        m_level = 0; m_head = 0; m_wr = 0; exp_addr = 0;
        if (outstanding > 0) discard = 1;
      end else if (inv && lvl0 > 0) begin
        m_head = (m_head == FRAME - 1) ? 0 : m_head + 1;
        if (m_head == 0) saw_head_wrap = 1;
        m_level--;
      end
      if (set_u) m_under = 1; else if (ec) m_under = 0;
      if (set_e) m_err = 1;   else if (ec) m_err = 0;
    end
    check("level", 32'(level), 32'(m_level));
    check("empty", 32'(empty), 32'(m_level == 0));
    check("underrun", 32'(underrun), 32'(m_under));
    check("mem_err", 32'(mem_err), 32'(m_err));
    if (chk_rgb) check("rgb", 32'(rgb), 32'(exp_rgb));
  endtask

  initial begin
    int mark, lvl_hold;
    rst_n = 0; calib_done = 0; invalidate = 0; resync = 0; err_clear = 0; x_coord = 0;
    bus.mem_cmd_full = 0; bus.mem_rd_data = 0; bus.mem_rd_empty = 1;
    bus.mem_rd_overflow = 0; bus.mem_rd_error = 0;
    m_level = 0; m_head = 0; m_wr = 0; outstanding = 0; exp_addr = 0; ncmd = 0; npop = 0;
    last_addr = -1; discard = 0; m_under = 0; m_err = 0; saw_addr_wrap = 0; saw_head_wrap = 0;
    fifo_off = 0; stall_pct = 0; full_pct = 0; force_x = -1;
    for (int i = 0; i < 256; i++) begin ring[i] = 8'h0; known[i] = 0; end

    // reset state
    repeat (3) @(negedge clk);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_cmd_en", 32'(bus.mem_cmd_en), 32'd0);
    check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    rst_n = 1;
    calib_done = 1;

    // initial fill: two bursts then saturation
    for (int i = 0; i < 80 && npop < BURST; i++) step(0, 0, 0, 0, 0);
    check("burst1_level", 32'(level), 32'd128);
    for (int i = 0; i < 120 && m_level < 256; i++) step(0, 0, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0, 0);
    check("full_level", 32'(level), 32'd256);
    check("cmd_count2", 32'(ncmd), 32'd2);
    check("cmd2_addr", 32'(last_addr), 32'h80);

    // retire half the ring, expect exactly one refill
    repeat (4 * BURST) step(1, 0, 0, 0, 0);
    check("inv_level", 32'(level), 32'd128);
    repeat (60) step(1'($urandom_range(0, 1)), 0, 0, 0, 0);
    check("cmd_count3", 32'(ncmd), 32'd3);

    // frame wrap of fetch address and head
    stall_pct = 10; full_pct = 10;
    for (int i = 0; i < 60000 && !(saw_addr_wrap && saw_head_wrap); i++) step(1, 0, 0, 0, 0);
    check("addr_wrap", 32'(saw_addr_wrap), 32'd1);
    check("head_wrap", 32'(saw_head_wrap), 32'd1);

    // random traffic
    stall_pct = 30; full_pct = 20;
    for (int i = 0; i < 2500; i++) begin
      calib_done = ($urandom_range(0, 99) >= 8);
      step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 1, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2);
    end
    calib_done = 1; stall_pct = 0; full_pct = 0;

    // resync after 10 of 32 words
    fifo_off = 1;
    step(0, 1, 0, 0, 0);
    fifo_off = 0;
    for (int i = 0; i < 200 && !(outstanding == BURST - 10 && !discard); i++) step(0, 0, 0, 0, 0);
    check("rs_setup", 32'(outstanding), 32'(BURST - 10));
    step(0, 1, 0, 0, 0);
    check("rs_level", 32'(level), 32'd0);
    mark = ncmd;
    for (int i = 0; i < 100 && ncmd == mark; i++) step(0, 0, 0, 0, 0);
    check("rs_next_cmd", 32'(ncmd), 32'(mark + 1));
    check("rs_next_addr", 32'(last_addr), 32'd0);

    // underrun and error flags
    fifo_off = 1;
    step(0, 1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("under_set", 32'(underrun), 32'd1);
    check("under_level", 32'(level), 32'd0);
    step(0, 0, 1, 0, 0);
    check("under_clr", 32'(underrun), 32'd0);
    step(0, 0, 0, 1, 0);
    check("err_set", 32'(mem_err), 32'd1);
    step(0, 0, 1, 0, 1);
    check("err_set_wins", 32'(mem_err), 32'd1);
    step(0, 0, 1, 0, 0);
    check("err_clr", 32'(mem_err), 32'd0);

    // calibration drop mid-burst, then verify ring contents
    fifo_off = 0;
    for (int i = 0; i < 200 && !(outstanding > 0 && outstanding <= 20 && !discard); i++) step(0, 0, 0, 0, 0);
    lvl_hold = m_level;
    calib_done = 0;
    repeat (10) step(0, 0, 0, 0, 0);
    check("frozen_level", 32'(level), 32'(lvl_hold));
    check("frozen_rd_en", 32'(bus.mem_rd_en), 32'd0);
    calib_done = 1;
    for (int i = 0; i < 300 && !(m_level == 256 && outstanding == 0); i++) step(0, 0, 0, 0, 0);
    check("fill_level", 32'(level), 32'd256);
    for (int x = 0; x < 256; x++) begin
      force_x = x;
      step(0, 0, 0, 0, 0);
      check("scan", 32'(rgb), 32'(pix((m_head + ((x - m_head) & 255)) % FRAME)));
    end
    force_x = -1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vga_line_prefetch.md
# vga_line_prefetch

Parametrised circular prefetch buffer between the memory-controller read port and the VGA scan-out logic. It streams graphics memory into a block-RAM ring in fixed-length bursts and serves one pixel per cycle addressed by x coordinate. Compared with the fixed 256-byte line buffer it adds:
- configurable screen, depth and burst geometry;
- a frame resync input that flushes the ring and discards in-flight bursts;
- sticky underrun and memory-error flags;
- a fill-level output.

## Interface
- SCREEN_W, 256, pixels per line (bytes, 8-bit colour)
- SCREEN_H, 192, lines per frame
- BUF_DEPTH, 256, ring size in bytes; power of two; ≥ 8*BURST_WORDS
- BURST_WORDS, 32, 32-bit words per read command (1..64); SCREEN_W*SCREEN_H must be a multiple of 4*BURST_WORDS
- ADDR_PREFIX, 14'h0000, upper 14 bits of every 30-bit byte address
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- calib_done  in  1  memory ready; low freezes all state except reset
- x_coord  in  8  pixel column; ring index = x_coord mod BUF_DEPTH
- invalidate  in  1  retire oldest valid byte
- resync  in  1  single-cycle pulse: restart at frame byte 0
- err_clear  in  1  clears underrun and mem_err
- rgb  out  8  pixel at ring index, registered
- empty  out  1  valid_len == 0
- level  out  clog2(BUF_DEPTH)+1  valid_len
- underrun  out  1  sticky: invalidate seen while empty
- mem_err  out  1  sticky: mem_rd_error or mem_rd_overflow seen
- mem_cmd_en  out  1; mem_cmd_instr  out  3 (constant 3'b001); mem_cmd_bl  out  6 (constant BURST_WORDS-1); mem_cmd_byte_addr  out  30
- mem_cmd_full  in  1; mem_rd_en  out  1; mem_rd_data  in  32; mem_rd_empty  in  1; mem_rd_overflow  in  1; mem_rd_error  in  1

## Operation
- Registers:
  - head: frame byte address of the oldest valid byte.
  - fetch_ptr: frame address of the next burst.
  - valid_len: valid bytes in the ring.
  - words_left: words still owed by the outstanding burst.
- At most one burst outstanding.
- Reset values: valid_len=0 (empty=1), head=fetch_ptr=0, state IDLE, mem_cmd_en=0, mem_rd_en=0, rgb=0, underrun=0, mem_err=0.
- States:
  - IDLE: if BUF_DEPTH − valid_len ≥ 4*BURST_WORDS, go to CMD.
  - CMD: assert mem_cmd_en for exactly one cycle when !mem_cmd_full, with mem_cmd_byte_addr = {ADDR_PREFIX, fetch_ptr}. Then load words_left=BURST_WORDS, advance fetch_ptr by 4*BURST_WORDS (wrapping to 0 at SCREEN_W*SCREEN_H), and go to READ.
  - READ: set mem_rd_en = !mem_rd_empty. For each popped word:
    - Write byte lanes [7:0],[15:8],[23:16],[31:24] to ring indices w, w+1, w+2, w+3, where w = write pointer mod BUF_DEPTH.
    - Add 4 to valid_len and decrement words_left.
    - When words_left reaches 0, go to IDLE.
  - DRAIN: pop and discard words (no RAM write, valid_len unchanged) until words_left=0, then go to IDLE.
- Invalidate:
  - If !empty: head += 1, wrapping to 0 at SCREEN_W*SCREEN_H; valid_len −= 1.
  - If empty: ignored, and underrun is set.
- A word pop and an invalidate in the same cycle give valid_len += 3.
- Resync:
  - head=fetch_ptr=0 and valid_len=0. An invalidate in the same cycle is ignored and does not set underrun.
  - If in READ with words_left>0: go to DRAIN.
  - If in CMD: the command is not issued; go to IDLE.
- mem_rd_error or mem_rd_overflow high in any cycle sets mem_err. Buffering continues.
- err_clear clears both sticky flags; a set event in the same cycle wins.
- calib_done low: no commands, no pops, registers hold, rgb still updates.

## Timing
- rgb is valid one cycle after x_coord is presented (synchronous BRAM read).
- A pixel written in cycle t is readable via x_coord in cycle t+1 and appears on rgb at t+2.
- IDLE→CMD takes 1 cycle. mem_cmd_en can assert at the earliest 2 cycles after the free-space condition holds.
- Popping sustains 1 word per cycle while !mem_rd_empty. The RAM write occurs in the pop cycle, and valid_len/level update on the following edge.
- Ring wrap: the byte after index BUF_DEPTH−1 is index 0. The frame wrap of head and fetch_ptr is independent of the ring wrap.
- rst_n assertion mid-burst returns to reset values immediately. Words remaining in the memory FIFO are not drained; the memory controller is reset with the same reset.

## Test plan
- Reset, then calib_done=1 with the FIFO always supplying words: the first command has addr {ADDR_PREFIX,16'h0000} and bl=31; level reaches 128 after 32 pops; a second command with addr 0x0080 follows; level saturates at 256 with no further commands.
- Full buffer, invalidate held 4*BURST_WORDS cycles: head=128, level=128, then exactly one new command is issued. A pop coinciding with invalidate gives a +3 level step.
- Frame wrap: stream until fetch_ptr passes 49151; the next command address low 16 bits = 0x0000. head wraps 49151→0.
- Resync after 10 of 32 words popped: level=0, the remaining 22 words are popped without RAM writes, then the next command is at addr 0.
- invalidate while empty: level stays 0 and underrun=1. err_clear clears it. mem_rd_overflow pulse sets mem_err.
- calib_done=0 mid-READ: mem_rd_en=0 and level frozen. On release, popping resumes with no lost or duplicated word (check byte pattern at x=0..255).
